// File: rtl/tone_detect.sv
// rtl/tone_detect.sv - Goertzel single-bin tone detector with per-block power and threshold flag
module tone_detect #(
    parameter int unsigned       N      = 64,
    parameter logic signed [9:0] COEF   = 10'sd320,
    parameter logic [47:0]       THRESH = 48'd1000000,
    parameter int unsigned       SW     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [7:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [47:0]       power,
    output logic              detect,
    output logic              out_valid
);
    localparam int unsigned AW   = 2 * SW + 1;
    localparam int unsigned PW   = SW + 10;
    localparam logic [11:0] LAST = 12'(N - 1);

    typedef enum logic [2:0] {ACC, P1, P2, P3, FIN} state_t;

    state_t               state_q, state_d;
    logic signed [SW-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [11:0]          count_q, count_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [47:0]          power_q, power_d;
    logic                 detect_q, detect_d;
    logic                 out_valid_q, out_valid_d;

    logic signed [PW-1:0] prod, fb;
    logic signed [AW-1:0] s1_w, s2_w, fb_w;
    logic [47:0]          pow_val;

    // Feedback term (COEF*s1)>>>8 is shared by the resonator update and the P3 cross term.
    assign prod    = PW'(COEF) * PW'(s1_q);
    assign fb      = prod >>> 8;
    assign s1_w    = AW'(s1_q);
    assign s2_w    = AW'(s2_q);
    assign fb_w    = AW'(fb);
    assign pow_val = acc_q[AW-1] ? 48'd0 : 48'(acc_q);

    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        count_d     = count_q;
        acc_d       = acc_q;
        power_d     = power_q;
        detect_d    = detect_q;
        out_valid_d = 1'b0;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    s1_d    = SW'(in) + SW'(fb) - s2_q;
                    s2_d    = s1_q;
                    count_d = count_q + 12'd1;
                    if (count_q == LAST) state_d = P1;
                end
            end
            P1: begin
                acc_d   = s1_w * s1_w;
                state_d = P2;
            end
            P2: begin
                acc_d   = acc_q + s2_w * s2_w;
                state_d = P3;
            end
            P3: begin
                acc_d   = acc_q - fb_w * s2_w;
                state_d = FIN;
            end
            FIN: begin
                power_d     = pow_val;
                detect_d    = (pow_val >= THRESH);
                out_valid_d = 1'b1;
                s1_d        = '0;
                s2_d        = '0;
                count_d     = '0;
                state_d     = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACC;
            s1_q        <= '0;
            s2_q        <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            power_q     <= '0;
            detect_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            power_q     <= power_d;
            detect_q    <= detect_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign power     = power_q;
    assign detect    = detect_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_tone_detect.sv
// tb/tb_tone_detect.sv - bench for tone_detect: directed spec cases plus randomized blocks vs queue model
module tb_tone_detect;
    logic clk = 1'b0;
    logic reset;
    logic signed [7:0] x_ab, x_c;
    logic v_ab, v_c;
    logic rdy_a, det_a, ov_a, rdy_b, det_b, ov_b, rdy_c, det_c, ov_c;
    logic [47:0] pow_a, pow_b, pow_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_detect #(.N(4), .COEF(10'sd320), .THRESH(48'd1000000), .SW(24)) dut_a (
        .clk(clk), .reset(reset), .in(x_ab), .in_valid(v_ab), .in_ready(rdy_a),
        .power(pow_a), .detect(det_a), .out_valid(ov_a));
    tone_detect #(.N(4), .COEF(10'sd0), .THRESH(48'd10000), .SW(24)) dut_b (
        .clk(clk), .reset(reset), .in(x_ab), .in_valid(v_ab), .in_ready(rdy_b),
        .power(pow_b), .detect(det_b), .out_valid(ov_b));
    tone_detect #(.N(16), .COEF(10'sd362), .THRESH(48'd200000), .SW(24)) dut_c (
        .clk(clk), .reset(reset), .in(x_c), .in_valid(v_c), .in_ready(rdy_c),
        .power(pow_c), .detect(det_c), .out_valid(ov_c));

    // Reference: Goertzel block power from plain integer arithmetic on the whole sample list.
    function automatic longint wrapn(input longint v, input int bits);
        longint m = longint'(1) << bits;
        longint r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic longint floor256(input longint p);
        longint q = p / 256;
        if ((p % 256) != 0 && p < 0) q -= 1;
        return q;
    endfunction

    function automatic longint ref_power(input int coef, input int sw, input int blk[$]);
        longint s1 = 0, s2 = 0, sn, acc;
        foreach (blk[k]) begin
            sn = wrapn(longint'(blk[k]) + floor256(coef * s1) - s2, sw);
            s2 = s1;
            s1 = sn;
        end
        acc = wrapn(s1 * s1 + s2 * s2 - floor256(coef * s1) * s2, 2 * sw + 1);
        return (acc < 0) ? 0 : acc;
    endfunction

    task automatic send_ab(input int s);
        x_ab = 8'(s);
        v_ab = 1'b1;
        for (int t = 0; t < 50 && !rdy_a; t++) @(negedge clk);
        if (!rdy_a) begin
            checks++; errors++;
            $display("FAIL send_ab_timeout: in_ready=%0b required 1", rdy_a);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_ab(input int blk[$], input bit drop_valid, input int hold_x,
                          output int lat, output int low);
        foreach (blk[k]) send_ab(blk[k]);
        lat = -1;
        low = 0;
        if (drop_valid) v_ab = 1'b0;
        else x_ab = 8'(hold_x);
        for (int i = 0; i < 20; i++) begin
            if (!rdy_a) low++;
            if (ov_a) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_c(input int s);
        x_c = 8'(s);
        v_c = 1'b1;
        for (int t = 0; t < 50 && !rdy_c; t++) @(negedge clk);
        if (!rdy_c) begin
            checks++; errors++;
            $display("FAIL send_c_timeout: in_ready=%0b required 1", rdy_c);
        end
        @(posedge clk);
        @(negedge clk);
        v_c = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", rdy_a); end
        checks++; if (pow_a !== 48'd0) begin errors++; $display("FAIL reset_power: got %0d want 0", pow_a); end
        checks++; if (det_a !== 1'b0) begin errors++; $display("FAIL reset_detect: got %0b want 0", det_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", ov_a); end
        checks++; if (rdy_c !== 1'b1 || pow_c !== 48'd0) begin
            errors++; $display("FAIL reset_c: ready %0b power %0d want 1 0", rdy_c, pow_c);
        end
        reset = 1'b0;
        v_ab  = 1'b0;
        v_c   = 1'b0;
    endtask

    task automatic test_impulse;
        int blk[$];
        int lat, low;
        blk = '{1, 0, 0, 0};
        run_ab(blk, 1'b1, 0, lat, low);
        checks++; if (lat !== 4) begin errors++; $display("FAIL impulse_latency: got %0d want 4", lat); end
        checks++; if (low !== 4) begin errors++; $display("FAIL impulse_ready_low: got %0d want 4", low); end
        checks++; if (pow_a !== 48'd1) begin errors++; $display("FAIL impulse_power_a: got %0d want 1", pow_a); end
        checks++; if (det_a !== 1'b0) begin errors++; $display("FAIL impulse_detect_a: got %0b want 0", det_a); end
        checks++; if (pow_b !== 48'd1 || ov_b !== 1'b1) begin
            errors++; $display("FAIL impulse_b: power %0d ov %0b want 1 1", pow_b, ov_b);
        end
        @(negedge clk);
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL impulse_strobe_width: got %0b want 0", ov_a); end
        checks++; if (pow_a !== 48'd1) begin errors++; $display("FAIL impulse_power_hold: got %0d want 1", pow_a); end
    endtask

    task automatic test_fs4;
        int blk[$];
        int lat, low;
        longint ea;
        blk = '{100, 0, -100, 0};
        ea = ref_power(320, 24, blk);
        run_ab(blk, 1'b1, 0, lat, low);
        checks++; if (pow_b !== 48'd40000) begin errors++; $display("FAIL fs4_power_b: got %0d want 40000", pow_b); end
        checks++; if (det_b !== 1'b1) begin errors++; $display("FAIL fs4_detect_b: got %0b want 1", det_b); end
        checks++; if (pow_a !== 48'(ea) || det_a !== (ea >= 1000000)) begin
            errors++; $display("FAIL fs4_a: power %0d detect %0b want %0d", pow_a, det_a, ea);
        end
    endtask

    task automatic test_dc;
        int blk[$];
        int lat, low;
        longint ea;
        blk = '{10, 10, 10, 10};
        ea = ref_power(320, 24, blk);
        run_ab(blk, 1'b1, 0, lat, low);
        checks++; if (pow_b !== 48'd0 || det_b !== 1'b0) begin
            errors++; $display("FAIL dc_b: power %0d detect %0b want 0 0", pow_b, det_b);
        end
        checks++; if (pow_a !== 48'(ea)) begin errors++; $display("FAIL dc_a: got %0d want %0d", pow_a, ea); end
    endtask

    task automatic test_back_to_back;
        int blk[$];
        int lat1, low1, lat2, low2;
        logic [47:0] p1a, p1b;
        longint ea, eb;
        for (int k = 0; k < 4; k++) blk.push_back(int'($urandom_range(255)) - 128);
        ea = ref_power(320, 24, blk);
        eb = ref_power(0, 24, blk);
        run_ab(blk, 1'b0, blk[0], lat1, low1);
        p1a = pow_a;
        p1b = pow_b;
        checks++; if (low1 !== 4 || lat1 !== 4) begin
            errors++; $display("FAIL b2b_first_window: low %0d lat %0d want 4 4", low1, lat1);
        end
        checks++; if (p1a !== 48'(ea) || p1b !== 48'(eb)) begin
            errors++; $display("FAIL b2b_first_power: a %0d b %0d want %0d %0d", p1a, p1b, ea, eb);
        end
        run_ab(blk, 1'b1, 0, lat2, low2);
        checks++; if (low2 !== 4 || lat2 !== 4) begin
            errors++; $display("FAIL b2b_second_window: low %0d lat %0d want 4 4", low2, lat2);
        end
        checks++; if (pow_a !== p1a || pow_b !== p1b) begin
            errors++; $display("FAIL b2b_repeat_power: a %0d b %0d want %0d %0d", pow_a, pow_b, p1a, p1b);
        end
    endtask

    task automatic test_reset_mid;
        int blk[$];
        int lat, low;
        bit saw_ov;
        longint ea;
        blk = '{50, -20, 70, 5};
        foreach (blk[k]) send_ab(blk[k]);
        v_ab = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        saw_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ov_a || ov_b) saw_ov = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_ov !== 1'b0) begin errors++; $display("FAIL midreset_no_strobe: got %0b want 0", saw_ov); end
        checks++; if (pow_a !== 48'd0 || pow_b !== 48'd0 || rdy_a !== 1'b1) begin
            errors++; $display("FAIL midreset_state: a %0d b %0d ready %0b want 0 0 1", pow_a, pow_b, rdy_a);
        end
        blk = '{-90, 33, 12, -7};
        ea = ref_power(320, 24, blk);
        run_ab(blk, 1'b1, 0, lat, low);
        checks++; if (lat !== 4 || pow_a !== 48'(ea) || pow_b !== 48'(ref_power(0, 24, blk))) begin
            errors++; $display("FAIL midreset_next_block: lat %0d a %0d b %0d want 4 %0d", lat, pow_a, pow_b, ea);
        end
    endtask

    task automatic test_random_c;
        int tbl[8];
        tbl = '{0, 90, 127, 90, 0, -90, -127, -90};
        for (int b = 0; b < 8; b++) begin
            int blk[$];
            int amp, s, lat;
            longint ec;
            amp = int'($urandom_range(127));
            for (int k = 0; k < 16; k++) begin
                if (b % 2 == 0) s = tbl[(2 * k) % 8] * amp / 127 + int'($urandom_range(8)) - 4;
                else s = int'($urandom_range(255)) - 128;
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                blk.push_back(s);
            end
            ec = ref_power(362, 24, blk);
            foreach (blk[k]) begin
                if ($urandom_range(3) == 0) @(negedge clk);
                send_c(blk[k]);
            end
            lat = -1;
            for (int i = 0; i < 20; i++) begin
                if (ov_c) begin
                    lat = i;
                    break;
                end
                @(negedge clk);
            end
            checks++; if (lat !== 4) begin errors++; $display("FAIL rand_latency blk%0d: got %0d want 4", b, lat); end
            checks++; if (pow_c !== 48'(ec) || det_c !== (ec >= 200000)) begin
                errors++; $display("FAIL rand_power blk%0d: power %0d detect %0b want %0d", b, pow_c, det_c, ec);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        v_ab  = 1'b1;
        x_ab  = 8'sd55;
        v_c   = 1'b1;
        x_c   = 8'sd55;
        test_reset;
        test_impulse;
        test_fs4;
        test_dc;
        test_back_to_back;
        test_reset_mid;
        test_random_c;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_detect.md
# tone_detect

Goertzel single-bin tone detector: the receive-side counterpart of the sine generator. It consumes a stream of signed 8-bit samples, runs the second-order resonator s[n] = x[n] + (COEF·s[n-1])>>>8 − s[n-2] over a block of N samples, then computes the bin power and compares it against a threshold. It sits downstream of the ADC/sample path and feeds the control logic with a per-block power value and a tone-present flag.

## Interface
- N, default 64: samples per block, 2..4095.
- COEF, default 320: 2·cos(2πk/N) in signed Q2.8, 10 bits; 320 = 1.25, the generator's resonance.
- THRESH, default 1000000: detect threshold on power, unsigned 48-bit.
- SW, default 24: signed width of the resonator state registers.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- in  in  8  signed input sample.
- in_valid  in  1  sample present on `in`.
- in_ready  out  1  block can accept a sample this cycle.
- power  out  48  unsigned bin power of the last completed block.
- detect  out  1  power ≥ THRESH for the last completed block.
- out_valid  out  1  one-cycle strobe: power/detect just updated.

## Operation
- Reset values: s1 = s2 = 0, count = 0, state ACC, in_ready = 1, power = 0, detect = 0, out_valid = 0.
- Accept: a sample is taken on a rising edge where in_valid && in_ready. in_valid while in_ready = 0 is ignored; upstream holds the sample.
- States:
  - ACC: in_ready = 1. On accept, compute s_new = sext(in) + ((COEF·s1)>>>8) − s2, then s2 ← s1, s1 ← s_new, count++. When count reaches N−1 on the accepting edge, go to P1.
  - P1: acc ← s1·s1. Go to P2.
  - P2: acc ← acc + s2·s2. Go to P3.
  - P3: acc ← acc − ((COEF·s1)>>>8)·s2. Go to FIN.
  - FIN: power ← (acc < 0) ? 0 : acc[47:0]; detect ← (that value ≥ THRESH); out_valid ← 1; s1, s2, count ← 0. Go to ACC.
- in_ready = 1 only in ACC.
- Arithmetic rules:
  - `>>>` is an arithmetic shift, so it floors.
  - The COEF·s1 product is SW+10 bits.
  - State updates wrap modulo 2^SW. N must be chosen so the state stays in range; there is no saturation on the state.
  - acc is signed, 2·SW+1 bits. Only the clamp to ≥ 0 is applied.
- power and detect hold their values until the next FIN. out_valid is high only in the cycle following FIN.
- Reset mid-block or mid-P1..FIN: the partial block is discarded, all registers return to reset values, and no out_valid is produced.
- Simultaneous events: none are possible. No sample is accepted in P1..FIN, and ACC is re-entered with cleared state.

## Timing
- Edge E0 accepts sample N−1 and enters P1. E1 ends P1, E2 ends P2, E3 ends P3.
- E4 ends FIN and registers the outputs, so out_valid is high in the cycle after E4.
- Latency is 4 clocks from accepting the last sample to out_valid.
- in_ready is low for exactly 4 cycles per block. It is high again in the out_valid cycle, so the first sample of the next block can be accepted at the edge ending that cycle.
- Maximum throughput is N samples per N+4 clocks.

## Test plan
- Reset: hold reset 2 cycles with in_valid = 1, in = 55 → in_ready = 1, power = 0, detect = 0, out_valid = 0; no sample is counted.
- Impulse (N = 4, COEF = 320): samples 1, 0, 0, 0 → s sequence 1, 1, 0, −1; power = 1, detect = 0; out_valid pulses 4 cycles after the 4th accept.
- fs/4 tone (N = 4, COEF = 0, THRESH = 10000): samples 100, 0, −100, 0 → final s1 = 0, s2 = −200; power = 40000, detect = 1.
- DC rejection (N = 4, COEF = 0): samples 10, 10, 10, 10 → power = 0, detect = 0.
- Backpressure: hold in_valid high continuously across two blocks.
  - in_ready low for 4 cycles each block, with no samples taken while low.
  - Second block yields the same power as the first for identical data.
- Reset mid-operation: assert reset during P2 → no out_valid; power keeps its reset value 0; the next full block produces the correct result.
